mem_stage: RTL and testbench

Memory-access and writeback stage of the pipeline: services the load/store requests that decode marks with `mem_rr`/`mem_we`, drives the data-cache request/response handshake, forms store byte-enables and load alignment/extension, and produces the registered register-file write port. While a memory access is outstanding it raises `stall` upstream. That stall is the same `stall` the decode stage consumes, so hazard bubbles and memory stalls compose.

---
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access / writeback stage: data-cache load/store handshake, store lane
// formatting, load alignment/extension and the registered register-file write port.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_rr,
    input  logic        mem_we,
    input  logic        reg_we,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dcache_req_valid,
    input  logic        dcache_req_ready,
    output logic [31:0] dcache_addr,
    output logic [3:0]  dcache_we,
    output logic [31:0] dcache_din,
    input  logic        dcache_resp_valid,
    input  logic [31:0] dcache_dout,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_we;

    logic        w_idle;
    logic        w_mem_req;
    logic        w_mis;
    logic        w_mem_op;

    // funct3[1:0] selects the size (00 byte, 01 half, anything else word); funct3[2] means unsigned.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return o[0];
            default: return (o != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] f_store_we(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 4'b0001 << o;
            2'b01:   return 4'b0011 << o;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_din(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [31:0] dout, input logic [1:0] o,
                                                   input logic [2:0] f3);
        logic [31:0] w;
        w = dout >> {o, 3'b000};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, w[7:0]}   : {{24{w[7]}}, w[7:0]};
            2'b01:   return f3[2] ? {16'b0, w[15:0]}  : {{16{w[15]}}, w[15:0]};
            default: return dout;
        endcase
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_mem_req = in_valid & (mem_rr | mem_we);
    assign w_mis     = f_misaligned(funct3, alu_result[1:0]);
    assign w_mem_op  = w_mem_req & ~w_mis;

    // Combinational handshake; forced quiet while reset is held.
    assign dcache_req_valid = ~rst & w_idle & w_mem_op;
    assign stall = ~rst & ((w_idle & w_mem_op & (~dcache_req_ready | mem_rr)) |
                           (~w_idle & ~dcache_resp_valid));

    assign dcache_addr = {alu_result[31:2], 2'b00};
    assign dcache_we   = (mem_we & ~mem_rr) ? f_store_we(funct3, alu_result[1:0]) : 4'b0000;
    assign dcache_din  = f_store_din(funct3, store_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_mem_req & w_mis) begin
                    misaligned <= 1'b1;
                end else if (w_mem_op) begin
                    // Loads keep their own copy of address/format/rd; upstream moves on after accept.
                    if (dcache_req_ready & mem_rr) begin
                        r_state  <= S_RESP;
                        r_off    <= alu_result[1:0];
                        r_funct3 <= funct3;
                        r_rd     <= rd;
                        r_reg_we <= reg_we;
                    end
                end else if (in_valid & reg_we & (rd != 5'd0)) begin
                    wb_we   <= 1'b1;
                    wb_rd   <= rd;
                    wb_data <= alu_result;
                end
            end else begin
                if (dcache_resp_valid) begin
                    r_state <= S_IDLE;
                    if (r_reg_we & (r_rd != 5'd0)) begin
                        wb_we   <= 1'b1;
                        wb_rd   <= r_rd;
                        wb_data <= f_load_extract(dcache_dout, r_off, r_funct3);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random loads, stores and ALU ops
// checked against an arithmetic reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_rr, mem_we, reg_we;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result, store_data;
    logic        dcache_req_valid, dcache_req_ready;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic        dcache_resp_valid;
    logic [31:0] dcache_dout;
    logic        stall, wb_we, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rr(mem_rr), .mem_we(mem_we),
        .reg_we(reg_we), .funct3(funct3), .rd(rd), .alu_result(alu_result),
        .store_data(store_data), .dcache_req_valid(dcache_req_valid),
        .dcache_req_ready(dcache_req_ready), .dcache_addr(dcache_addr),
        .dcache_we(dcache_we), .dcache_din(dcache_din),
        .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout),
        .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; mem_rr = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
        funct3 = 3'd0; rd = 5'd0; alu_result = 32'd0; store_data = 32'd0;
        dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
    endtask

    // Reference model: access size in bytes, from the size code.
    function automatic int sz(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) % sz(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_we(input logic [31:0] a, input logic [2:0] f3);
        if (sz(f3) == 4) return 4'hF;
        return 4'(((1 << sz(f3)) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_din(input logic [31:0] sd, input logic [2:0] f3);
        if (sz(f3) == 1) return 32'(sd[7:0]) * 32'h01010101;
        if (sz(f3) == 2) return 32'(sd[15:0]) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] dout, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v, mask;
        int bits;
        if (sz(f3) == 4) return dout;
        bits = 8 * sz(f3);
        mask = 32'((64'd1 << bits) - 64'd1);
        v = (dout >> (8 * int'(a[1:0]))) & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // kind: 0 ALU, 1 load, 2 store. rdly = cycles ready is held low, pdly = cycles to response.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] dst, input logic rwe,
                          input int rdly, input int pdly, input logic [31:0] dout);
        bit ismem, isld, mis, expw;
        ismem = (kind != 0);
        isld  = (kind == 1);
        mis   = ismem && model_mis(addr, f3);
        in_valid = 1'b1; mem_rr = isld; mem_we = (kind == 2); reg_we = rwe;
        funct3 = f3; rd = dst; alu_result = addr; store_data = sd;
        dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
        if (!ismem || mis) begin
            dcache_resp_valid = 1'($urandom);
            #1;
            chk("nomem_req_valid", dcache_req_valid, 0);
            chk("nomem_stall", stall, 0);
            step();
            idle_inputs();
            expw = !ismem && rwe && (dst != 5'd0);
            if (expw) begin m_rd = dst; m_data = addr; end
            chk("misaligned", misaligned, mis);
            chk("alu_wb_we", wb_we, expw);
            chk("alu_wb_rd", wb_rd, m_rd);
            chk("alu_wb_data", wb_data, m_data);
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            dcache_req_ready  = (i == rdly);
            dcache_resp_valid = 1'($urandom);
            #1;
            chk("req_valid", dcache_req_valid, 1);
            chk("req_stall", stall, (i < rdly) || isld);
            chk("req_addr", dcache_addr, {addr[31:2], 2'b00});
            chk("req_we", dcache_we, isld ? 4'h0 : model_we(addr, f3));
            if (!isld) chk("req_din", dcache_din, model_din(sd, f3));
            step();
        end
        idle_inputs();
        if (!isld) begin
            chk("st_wb_we", wb_we, 0);
            chk("st_misaligned", misaligned, 0);
            chk("st_wb_data", wb_data, m_data);
            return;
        end
        for (int j = 1; j <= pdly; j++) begin
            dcache_resp_valid = (j == pdly);
            dcache_dout = (j == pdly) ? dout : $urandom;
            #1;
            chk("resp_req_valid", dcache_req_valid, 0);
            chk("resp_stall", stall, j < pdly);
            step();
        end
        dcache_resp_valid = 1'b0;
        expw = rwe && (dst != 5'd0);
        if (expw) begin m_rd = dst; m_data = model_load(dout, addr, f3); end
        chk("ld_wb_we", wb_we, expw);
        chk("ld_wb_rd", wb_rd, m_rd);
        chk("ld_wb_data", wb_data, m_data);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [31:0] a;
        int kind;
        logic [2:0] f3;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset with a load request presented: handshake outputs must stay quiet.
        idle_inputs();
        dcache_dout = 32'd0;
        rst = 1'b1;
        in_valid = 1'b1; mem_rr = 1'b1; funct3 = 3'd2; alu_result = 32'h200;
        dcache_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", dcache_req_valid, 0);
        chk("rst_stall", stall, 0);
        step();
        step();
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_misaligned", misaligned, 0);
        rst = 1'b0;
        idle_inputs();
        step();

        // Directed scenarios.
        run_op(2, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 0, 0, 32'd0);
        run_op(2, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1'b0, 2, 0, 32'd0);
        run_op(1, 3'b001, 32'h102, 32'd0, 5'd5, 1'b1, 0, 3, 32'h80FF1234);
        chk("lh_value", wb_data, 32'hFFFF80FF);
        run_op(1, 3'b101, 32'h102, 32'd0, 5'd5, 1'b1, 0, 3, 32'h80FF1234);
        chk("lhu_value", wb_data, 32'h000080FF);
        run_op(1, 3'b010, 32'h101, 32'd0, 5'd3, 1'b1, 0, 1, 32'd0);
        run_op(0, 3'b000, 32'h42, 32'd0, 5'd0, 1'b1, 0, 0, 32'd0);
        run_op(0, 3'b000, 32'h42, 32'd0, 5'd7, 1'b1, 0, 0, 32'd0);
        chk("add_value", wb_data, 32'h42);

        // Reset while waiting for a response; the late response must be ignored.
        in_valid = 1'b1; mem_rr = 1'b1; reg_we = 1'b1; rd = 5'd9; funct3 = 3'd2;
        alu_result = 32'h300; dcache_req_ready = 1'b1;
        #1;
        chk("rr_accept_stall", stall, 1);
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rr_rst_stall", stall, 0);
        step();
        rst = 1'b0;
        dcache_resp_valid = 1'b1;
        dcache_dout = 32'h12345678;
        #1;
        chk("rr_late_stall", stall, 0);
        step();
        dcache_resp_valid = 1'b0;
        m_rd = 5'd0;
        m_data = 32'd0;
        chk("rr_wb_we", wb_we, 0);
        chk("rr_wb_rd", wb_rd, 0);
        chk("rr_wb_data", wb_data, 0);
        chk("rr_misaligned", misaligned, 0);

        // Random mix of operations.
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] :
                 (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            run_op(kind, f3, a, $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
